// File: rtl/config_register_file.sv
// Block of NUM_REGS config words on a shared address/data bus, with optional shadow/commit buffering.
// Latency: write to shadow is 1 edge; read-back data and valid 1 cycle after config_read; commit is 1 edge.
// Backpressure: none; every bus cycle is accepted, and unmapped accesses pulse config_err.
module config_register_file #(
  parameter int          NUM_REGS      = 4,
  parameter int          DATA_WIDTH    = 32,
  parameter int          ADDR_WIDTH    = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter bit          DOUBLE_BUFFER = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          config_addr,
  input  logic [DATA_WIDTH-1:0]          config_data,
  input  logic                           config_write,
  input  logic                           config_read,
  input  logic                           config_commit,
  output logic [DATA_WIDTH-1:0]          read_config_data,
  output logic                           read_config_valid,
  output logic                           config_err,
  output logic                           pending,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Decode bounds carry one extra bit so BASE_ADDR+NUM_REGS never wraps.
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] END_EXT  = (ADDR_WIDTH+1)'(BASE_ADDR + NUM_REGS);

  logic [ADDR_WIDTH:0]   addr_ext;
  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic                  wr_hit;
  logic                  access;

  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] active_q [NUM_REGS];

  assign addr_ext = {1'b0, config_addr};
  assign hit      = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
  assign idx      = IDX_W'(addr_ext - BASE_EXT);
  assign wr_hit   = config_write && hit;
  assign access   = config_write || config_read;

  // Shadow words take every mapped write; they are also the read-back source.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_hit) begin
      shadow_q[idx] <= config_data;
    end
  end

  // Read-back: data sampled from shadow before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_config_data  <= '0;
      read_config_valid <= 1'b0;
    end else begin
      read_config_valid <= config_read;
      if (config_read) begin
        read_config_data <= hit ? shadow_q[idx] : '0;
      end
    end
  end

  // Unmapped write or read gives a single error pulse the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      config_err <= 1'b0;
    end else begin
      config_err <= access && !hit;
    end
  end

  generate
    if (DOUBLE_BUFFER) begin : g_double
      logic pending_q;

      // Commit copies every shadow word; a same-cycle write is folded in so it is not lost.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            active_q[i] <= '0;
          end
        end else if (config_commit) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit && (idx == IDX_W'(i))) begin
              active_q[i] <= config_data;
            end else begin
              active_q[i] <= shadow_q[i];
            end
          end
        end
      end

      // Pending tracks uncommitted writes; commit wins over a same-cycle write.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pending_q <= 1'b0;
        end else if (config_commit) begin
          pending_q <= 1'b0;
        end else if (wr_hit) begin
          pending_q <= 1'b1;
        end
      end

      assign pending = pending_q;
    end else begin : g_direct
      logic unused_commit;

      // Without buffering, mapped writes go straight to the core-facing words.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            active_q[i] <= '0;
          end
        end else if (wr_hit) begin
          active_q[idx] <= config_data;
        end
      end

      assign unused_commit = config_commit;
      assign pending       = 1'b0;
    end
  endgenerate

  // Core-facing words come straight from the active flops.
  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_config_register_file.sv
// Directed bench: one double-buffered and one direct-write instance share the bus stimulus.
// Table vectors cover decode, read/write/commit interplay; hand sequences cover reset mid-read and direct mode.
module tb_config_register_file;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   config_addr = '0;
  logic [31:0]  config_data = '0;
  logic         config_write = 1'b0;
  logic         config_read = 1'b0;
  logic         config_commit = 1'b0;

  logic [31:0]  rdata_db, rdata_sb;
  logic         vld_db, vld_sb;
  logic         err_db, err_sb;
  logic         pend_db, pend_sb;
  logic [127:0] regs_db, regs_sb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  config_register_file #(
    .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(32'h10), .DOUBLE_BUFFER(1'b1)
  ) dut_db (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read), .config_commit(config_commit),
    .read_config_data(rdata_db), .read_config_valid(vld_db), .config_err(err_db),
    .pending(pend_db), .reg_out(regs_db)
  );

  config_register_file #(
    .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(32'h10), .DOUBLE_BUFFER(1'b0)
  ) dut_sb (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read), .config_commit(config_commit),
    .read_config_data(rdata_sb), .read_config_valid(vld_sb), .config_err(err_sb),
    .pending(pend_sb), .reg_out(regs_sb)
  );

  typedef struct {
    logic         wr;
    logic         rd;
    logic         cm;
    logic [7:0]   addr;
    logic [31:0]  wdat;
    logic         e_vld;
    logic [31:0]  e_dat;
    logic         e_err;
    logic         e_pend;
    logic [127:0] e_regs;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic wr, input logic rd, input logic cm,
                              input logic [7:0] addr, input logic [31:0] wdat,
                              input logic e_vld, input logic [31:0] e_dat, input logic e_err,
                              input logic e_pend, input logic [127:0] e_regs);
    vec_t v;
    v.wr = wr; v.rd = rd; v.cm = cm; v.addr = addr; v.wdat = wdat;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_err = e_err; v.e_pend = e_pend; v.e_regs = e_regs;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle on the falling edge, then sample just after the rising edge.
  task automatic do_cycle(input logic wr, input logic rd, input logic cm,
                          input logic [7:0] addr, input logic [31:0] wdat);
    @(negedge clk);
    config_write  = wr;
    config_read   = rd;
    config_commit = cm;
    config_addr   = addr;
    config_data   = wdat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    config_write  = 1'b0;
    config_read   = 1'b0;
    config_commit = 1'b0;
  endtask

  initial begin
    logic [127:0] r_a, r_b, r_c, r_d, r_e;

    r_a = pack4(32'h11111111, 32'h0, 32'hDEADBEEF, 32'h0);
    r_b = pack4(32'h11111111, 32'h0, 32'hDEADBEEF, 32'hA5A5A5A5);
    r_c = pack4(32'h11111111, 32'h5, 32'hDEADBEEF, 32'hA5A5A5A5);
    r_d = pack4(32'h11111111, 32'h7, 32'hDEADBEEF, 32'hA5A5A5A5);
    r_e = '0;

    //              wr    rd    cm    addr   wdat          vld   dat           err   pend  regs
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b1, r_e);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'h12, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, r_e);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 8'h12, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b1, r_e);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 32'h11111111, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, r_e);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, r_a);
    vecs[5]  = mk(1'b1, 1'b0, 1'b1, 8'h13, 32'hA5A5A5A5, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, r_b);
    vecs[6]  = mk(1'b1, 1'b1, 1'b0, 8'h14, 32'h99,       1'b1, 32'h0,        1'b1, 1'b0, r_b);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, r_b);
    vecs[8]  = mk(1'b1, 1'b0, 1'b0, 8'h11, 32'h5,        1'b0, 32'h0,        1'b0, 1'b1, r_b);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, r_c);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 8'h11, 32'h7,        1'b1, 32'h5,        1'b0, 1'b1, r_c);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'h11, 32'h0,        1'b1, 32'h7,        1'b0, 1'b1, r_c);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 8'h13, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, r_c);
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 8'h14, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, r_c);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 8'h10, 32'h0,        1'b1, 32'h11111111, 1'b0, 1'b1, r_c);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        1'b0, 32'h11111111, 1'b0, 1'b0, r_d);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        1'b0, 32'h11111111, 1'b0, 1'b0, r_d);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 8'h0F, 32'hAAAAAAAA, 1'b0, 32'h11111111, 1'b1, 1'b0, r_d);

    // Reset state on both instances.
    #1;
    check("rst_dat", {96'h0, rdata_db}, 128'h0);
    check("rst_vld", {127'h0, vld_db}, 128'h0);
    check("rst_err", {127'h0, err_db}, 128'h0);
    check("rst_pend", {127'h0, pend_db}, 128'h0);
    check("rst_regs", regs_db, 128'h0);
    check("rst_regs_sb", regs_sb, 128'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven sequence on the double-buffered instance.
    for (int i = 0; i < NV; i++) begin
      do_cycle(vecs[i].wr, vecs[i].rd, vecs[i].cm, vecs[i].addr, vecs[i].wdat);
      check($sformatf("v%0d_vld", i), {127'h0, vld_db}, {127'h0, vecs[i].e_vld});
      check($sformatf("v%0d_dat", i), {96'h0, rdata_db}, {96'h0, vecs[i].e_dat});
      check($sformatf("v%0d_err", i), {127'h0, err_db}, {127'h0, vecs[i].e_err});
      check($sformatf("v%0d_pend", i), {127'h0, pend_db}, {127'h0, vecs[i].e_pend});
      check($sformatf("v%0d_regs", i), regs_db, vecs[i].e_regs);
    end
    @(negedge clk);
    idle_bus();

    // Load all words, commit, leave a write pending, then reset in the middle of a read.
    do_cycle(1'b1, 1'b0, 1'b0, 8'h10, 32'h01010101);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h11, 32'h02020202);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h12, 32'h03030303);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h13, 32'h04040404);
    do_cycle(1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
    check("load_regs", regs_db,
          pack4(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404));
    do_cycle(1'b1, 1'b0, 1'b0, 8'h10, 32'h77);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h12, 32'h0);
    check("pre_rst_vld", {127'h0, vld_db}, 128'h1);
    check("pre_rst_dat", {96'h0, rdata_db}, {96'h0, 32'h03030303});
    do_cycle(1'b0, 1'b1, 1'b0, 8'h13, 32'h0);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_vld", {127'h0, vld_db}, 128'h0);
    check("mid_rst_dat", {96'h0, rdata_db}, 128'h0);
    check("mid_rst_pend", {127'h0, pend_db}, 128'h0);
    check("mid_rst_err", {127'h0, err_db}, 128'h0);
    check("mid_rst_regs", regs_db, 128'h0);
    @(negedge clk);
    idle_bus();
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_vld0", {127'h0, vld_db}, 128'h0);
    @(posedge clk);
    #1;
    check("post_rst_vld1", {127'h0, vld_db}, 128'h0);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h12, 32'h0);
    check("post_rst_shadow", {96'h0, rdata_db}, 128'h0);

    // Direct-write instance: the write shows on reg_out after one edge, never pending.
    do_cycle(1'b1, 1'b0, 1'b0, 8'h12, 32'hDEADBEEF);
    check("sb_regs", regs_sb, pack4(32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
    check("sb_pend", {127'h0, pend_sb}, 128'h0);
    check("db_regs_held", regs_db, 128'h0);
    check("db_pend", {127'h0, pend_db}, 128'h1);
    do_cycle(1'b0, 1'b1, 1'b1, 8'h12, 32'h0);
    check("sb_rd_vld", {127'h0, vld_sb}, 128'h1);
    check("sb_rd_dat", {96'h0, rdata_sb}, {96'h0, 32'hDEADBEEF});
    check("sb_pend_cm", {127'h0, pend_sb}, 128'h0);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h20, 32'h12345678);
    check("sb_miss_err", {127'h0, err_sb}, 128'h1);
    check("sb_miss_regs", regs_sb, pack4(32'h0, 32'h0, 32'hDEADBEEF, 32'h0));
    @(negedge clk);
    idle_bus();
    @(posedge clk);
    #1;
    check("sb_err_clear", {127'h0, err_sb}, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
